// File: rtl/gate_pkg.sv
// Shared definitions for the parking-lot gate sensor front end.
//   gate_state_t     : passage-tracking FSM states
//   DEBOUNCE_DEFAULT : default number of stable synchronised cycles needed
//                      before a filtered sensor value flips
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EN_A,
        EN_AB,
        EN_B,
        EX_B,
        EX_BA,
        EX_A,
        ERR
    } gate_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debounce filter for one
// photo-sensor line.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   raw_i    : raw sensor line, asynchronous to clk
//   filt_o   : filtered sensor value
// The filtered value flips only after the synchronised value has differed
// from it on DEBOUNCE_CYCLES consecutive edges (legal range 1..255).
module sensor_debounce
    import gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    // Counter value on the edge that completes a full run.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // NOTE: every variable gets a default before any branch so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others (sync1 -> sync2 chain).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gate_sensor.sv
// Gate sensor front end: turns the outer (a) and inner (b) beam lines into
// single-cycle enter / exit / reject pulses for the lot controller.
//   clk      : system clock (controller's divided clock)
//   reset    : asynchronous active-low reset
//   sensor_a : raw outer beam, 1 = blocked
//   sensor_b : raw inner beam, 1 = blocked
//   full     : lot full flag from the controller
//   enter    : pulse, completed entry admitted
//   exit     : pulse, completed exit
//   reject   : pulse, completed entry while full
//   busy     : FSM is tracking a passage (state != IDLE)
module gate_sensor
    import gate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    input  logic full,
    output logic enter,
    output logic exit,
    output logic reject,
    output logic busy
);

    logic        fa;
    logic        fb;
    gate_state_t state_q;
    gate_state_t state_d;
    logic        enter_q,  enter_d;
    logic        exit_q,   exit_d;
    logic        reject_q, reject_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (reset),
        .raw_i  (sensor_a),
        .filt_o (fa)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (reset),
        .raw_i  (sensor_b),
        .filt_o (fb)
    );

    // Passage tracking: the exit path mirrors entry with a and b swapped.
    // Any pattern not listed for a state holds that state.
    always_comb begin
        state_d  = state_q;
        enter_d  = 1'b0;
        exit_d   = 1'b0;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                case ({fa, fb})
                    2'b10:   state_d = EN_A;
                    2'b01:   state_d = EX_B;
                    2'b11:   state_d = ERR;
                    default: state_d = IDLE;
                endcase
            end
            EN_A: begin
                case ({fa, fb})
                    2'b11:   state_d = EN_AB;
                    2'b00:   state_d = IDLE;    // balked, no pulse
                    2'b01:   state_d = ERR;
                    default: state_d = EN_A;
                endcase
            end
            EN_AB: begin
                case ({fa, fb})
                    2'b01:   state_d = EN_B;
                    2'b10:   state_d = EN_A;
                    2'b00:   state_d = ERR;
                    default: state_d = EN_AB;
                endcase
            end
            EN_B: begin
                case ({fa, fb})
                    2'b00: begin
                        state_d  = IDLE;
                        enter_d  = ~full;
                        reject_d = full;
                    end
                    2'b11:   state_d = EN_AB;
                    2'b10:   state_d = ERR;
                    default: state_d = EN_B;
                endcase
            end
            EX_B: begin
                case ({fa, fb})
                    2'b11:   state_d = EX_BA;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = ERR;
                    default: state_d = EX_B;
                endcase
            end
            EX_BA: begin
                case ({fa, fb})
                    2'b10:   state_d = EX_A;
                    2'b01:   state_d = EX_B;
                    2'b00:   state_d = ERR;
                    default: state_d = EX_BA;
                endcase
            end
            EX_A: begin
                case ({fa, fb})
                    2'b00: begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end
                    2'b11:   state_d = EX_BA;
                    2'b01:   state_d = ERR;
                    default: state_d = EX_A;
                endcase
            end
            ERR: begin
                if ({fa, fb} == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enter_q  <= enter_d;
            exit_q   <= exit_d;
            reject_q <= reject_d;
        end
    end

    assign enter  = enter_q;
    assign exit   = exit_q;
    assign reject = reject_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_gate_sensor.sv
module tb_gate_sensor;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic reset;
    logic sensor_a;
    logic sensor_b;
    logic full;
    logic enter;
    logic exit;
    logic reject;
    logic busy;

    int total = 0;
    int bad   = 0;

    gate_sensor #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .full     (full),
        .enter    (enter),
        .exit     (exit),
        .reject   (reject),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Filter: a synchronised sample is the raw input seen two edges earlier;
    // the filtered value flips after N consecutive disagreeing samples.
    bit m_raw1 [2];
    bit m_raw2 [2];
    bit m_f    [2];
    int m_run  [2];
    // Passage: direction (0 none, 1 entry, 2 exit, 3 error) and the
    // position reached along that direction's beam pattern sequence.
    int m_dir;
    int m_pos;
    bit m_enter, m_exit, m_reject;

    int n_enter, n_exit, n_reject, n_busy_rise;
    bit prev_busy;

    // Beam pattern {a,b} at each position of a passage; position 4 is the
    // final clear that completes it.
    function automatic logic [1:0] path_at(input int dir, input int idx);
        logic [1:0] r;
        r = 2'b00;
        if (idx >= 1 && idx <= 3) begin
            if (dir == 1) r = (idx == 1) ? 2'b10 : (idx == 2) ? 2'b11 : 2'b01;
            else          r = (idx == 1) ? 2'b01 : (idx == 2) ? 2'b11 : 2'b10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_raw1[i] = 0; m_raw2[i] = 0; m_f[i] = 0; m_run[i] = 0;
        end
        m_dir = 0; m_pos = 0;
        m_enter = 0; m_exit = 0; m_reject = 0;
    endtask

    task automatic model_edge();
        logic [1:0] p;
        bit raw [2];
        p = {m_f[0], m_f[1]};
        m_enter = 0; m_exit = 0; m_reject = 0;
        if (m_dir == 0) begin
            if (p == 2'b10)      begin m_dir = 1; m_pos = 1; end
            else if (p == 2'b01) begin m_dir = 2; m_pos = 1; end
            else if (p == 2'b11) m_dir = 3;
        end else if (m_dir == 3) begin
            if (p == 2'b00) m_dir = 0;
        end else begin
            if (p == path_at(m_dir, m_pos + 1)) begin
                m_pos++;
                if (m_pos == 4) begin
                    if (m_dir == 2)  m_exit = 1;
                    else if (full)   m_reject = 1;
                    else             m_enter = 1;
                    m_dir = 0;
                end
            end else if (p == path_at(m_dir, m_pos - 1)) begin
                m_pos--;
                if (m_pos == 0) m_dir = 0;
            end else if (p != path_at(m_dir, m_pos)) begin
                m_dir = 3;
            end
        end
        raw[0] = sensor_a;
        raw[1] = sensor_b;
        for (int i = 0; i < 2; i++) begin
            if (m_raw2[i] != m_f[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(N)) begin
                    m_f[i] = ~m_f[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_raw2[i] = m_raw1[i];
            m_raw1[i] = raw[i];
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        check("enter",  int'(enter),  int'(m_enter));
        check("exit",   int'(exit),   int'(m_exit));
        check("reject", int'(reject), int'(m_reject));
        check("busy",   int'(busy),   int'(m_dir != 0));
        check("onehot", int'(enter) + int'(exit) + int'(reject) <= 1 ? 1 : 0, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        compare_outputs();
        if (enter === 1'b1)  n_enter++;
        if (exit === 1'b1)   n_exit++;
        if (reject === 1'b1) n_reject++;
        if (busy === 1'b1 && !prev_busy) n_busy_rise++;
        prev_busy = (busy === 1'b1);
    endtask

    task automatic hold(input bit a, input bit b, input int cycles);
        sensor_a = a;
        sensor_b = b;
        repeat (cycles) tick();
    endtask

    task automatic clear_counts();
        n_enter = 0; n_exit = 0; n_reject = 0; n_busy_rise = 0;
    endtask

    task automatic entry_seq();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    endtask

    task automatic exit_seq();
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    endtask

    initial begin
        model_reset();
        clear_counts();
        prev_busy = 0;
        sensor_a = 0; sensor_b = 0; full = 0;
        reset = 1'b0;

        // 1: reset state, then a clean entry with room available
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b1;
        entry_seq();
        check("s1_enter_cnt",  n_enter, 1);
        check("s1_exit_cnt",   n_exit, 0);
        check("s1_reject_cnt", n_reject, 0);

        // 2: exit
        clear_counts();
        exit_seq();
        check("s2_exit_cnt",  n_exit, 1);
        check("s2_enter_cnt", n_enter, 0);

        // 3: entry while full, then with room
        clear_counts();
        full = 1;
        entry_seq();
        check("s3_reject_cnt", n_reject, 1);
        check("s3_enter_full", n_enter, 0);
        full = 0;
        entry_seq();
        check("s3_enter_cnt", n_enter, 1);

        // 4: balk then a short glitch on b
        clear_counts();
        hold(1, 0, 10); hold(0, 0, 10);
        hold(0, 1, 3);  hold(0, 0, 12);
        check("s4_pulses",    n_enter + n_exit + n_reject, 0);
        check("s4_busy_rise", n_busy_rise, 1);

        // 5: simultaneous break -> error, recovery, then a normal exit
        clear_counts();
        hold(1, 1, 10);
        check("s5_busy_err", int'(busy), 1);
        hold(0, 0, 10);
        check("s5_err_pulses", n_enter + n_exit + n_reject, 0);
        exit_seq();
        check("s5_exit_cnt", n_exit, 1);

        // 6: reset in the middle of an entry
        clear_counts();
        hold(1, 0, 10); hold(1, 1, 10);
        reset = 1'b0;
        sensor_a = 0; sensor_b = 0;
        model_reset();
        #1;
        check("s6_busy_async", int'(busy), 0);
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b1;
        hold(0, 0, 12);
        check("s6_no_enter", n_enter, 0);
        entry_seq();
        check("s6_enter_cnt", n_enter, 1);

        // Random beam patterns, durations and full flag against the model.
        for (int s = 0; s < 400; s++) begin
            full = 1'($urandom_range(0, 1));
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 12)));
        end
        hold(0, 0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
